// File: rtl/mips_pkg.sv
// Constants and payload layout shared by the MEM/WB latch and the write-back decoder.
package mips_pkg;

  localparam int unsigned DW   = 32;
  localparam int unsigned MW_W = 128;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_JAL = 6'b000011;

  localparam int unsigned MW_INSTR_LSB = 0;
  localparam int unsigned MW_ALU_LSB   = 32;
  localparam int unsigned MW_DATA_LSB  = 64;
  localparam int unsigned MW_LINK_LSB  = 96;

  // sll $0,$0,0 -- decodes as a harmless write to $0
  localparam logic [DW-1:0] BUBBLE = 32'h0000_0000;

  // Field order matches MW_*_LSB: link in the top word, instr in the bottom word
  typedef struct packed {
    logic [DW-1:0] link;
    logic [DW-1:0] data;
    logic [DW-1:0] alu;
    logic [DW-1:0] instr;
  } memwr_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_e;

endpackage

// File: rtl/load_align.sv
// Byte-lane selection and extension for loads; flags misaligned lw.
module load_align
  import mips_pkg::*;
(
  input  logic [5:0]    op,
  input  logic [1:0]    addr,
  input  logic [DW-1:0] rdata,
  output logic [DW-1:0] data,
  output logic          misalign
);

  logic [7:0] lane;

  // Little-endian: lane 0 is rdata[7:0]
  always_comb begin
    lane = rdata[7:0];
    case (addr)
      2'd0:    lane = rdata[7:0];
      2'd1:    lane = rdata[15:8];
      2'd2:    lane = rdata[23:16];
      default: lane = rdata[31:24];
    endcase
  end

  always_comb begin
    data     = rdata;
    misalign = 1'b0;
    case (op)
      OP_LB:   data = {{24{lane[7]}}, lane};
      OP_LBU:  data = {24'h0, lane};
      OP_LW:   misalign = (addr != 2'b00);
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_wr_stage_reg.sv
// MEM/WB pipeline latch driving the 128-bit memwr_reg bus, with stall/flush and slot tracking.
// Optional retirement counter enabled by defining MEMWR_RETIRE_CNT_EN.
module mem_wr_stage_reg #(
  parameter int unsigned DW     = 32,
  parameter logic [31:0] BUBBLE = mips_pkg::BUBBLE
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [DW-1:0] instr,
  input  logic [DW-1:0] alu_result,
  input  logic [DW-1:0] mem_rdata,
  input  logic [DW-1:0] link_addr,
`ifdef MEMWR_RETIRE_CNT_EN
  output logic [31:0]   retire_cnt,
`endif
  output logic [127:0]  memwr_reg,
  output logic          out_valid,
  output logic          addr_err
);

  import mips_pkg::*;

  slot_e           state_q, state_d;
  memwr_t          mw_q, mw_d;
  logic            err_q, err_d;
  logic [DW-1:0]   aligned;
  logic            misalign;

  load_align u_load_align (
    .op       (instr[31:26]),
    .addr     (alu_result[1:0]),
    .rdata    (mem_rdata),
    .data     (aligned),
    .misalign (misalign)
  );

  // Next slot contents: flush beats stall, stall beats load
  always_comb begin
    state_d = state_q;
    mw_d    = mw_q;
    err_d   = err_q;
    if (flush) begin
      state_d = SLOT_EMPTY;
      mw_d    = '{link: '0, data: '0, alu: '0, instr: BUBBLE};
      err_d   = 1'b0;
    end else if (!stall) begin
      state_d  = in_valid ? SLOT_FULL : SLOT_EMPTY;
      mw_d.link  = link_addr;
      mw_d.data  = aligned;
      mw_d.alu   = alu_result;
      mw_d.instr = in_valid ? instr : BUBBLE;
      err_d      = in_valid & misalign;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SLOT_EMPTY;
      mw_q    <= '{link: '0, data: '0, alu: '0, instr: BUBBLE};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mw_q    <= mw_d;
      err_q   <= err_d;
    end
  end

  assign memwr_reg = mw_q;
  assign out_valid = (state_q == SLOT_FULL);
  assign addr_err  = err_q;

`ifdef MEMWR_RETIRE_CNT_EN
  logic [31:0] cnt_q;

  // Counts instructions accepted into the slot; flush does not clear it
  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= 32'h0;
    else if (!flush && !stall && in_valid)
      cnt_q <= cnt_q + 32'd1;
  end

  assign retire_cnt = cnt_q;
`endif

endmodule
